// File: rtl/dac_gain_ramp_pkg.sv
// Purpose: shared FSM state type and default parameters for the DAC gain ramp controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dac_gain_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DWELL    = 2'd3
  } state_t;

  localparam int unsigned GAIN_WIDTH_DEF     = 8;
  localparam int unsigned GAIN_INIT_DEF      = 0;
  localparam int unsigned STEP_MAX_DEF       = 4;
  localparam int unsigned HOLD_CYCLES_DEF    = 1000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

  // Sizing helper for the shared wait/dwell counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dac_gain_ramp_ctrl.sv
// Purpose: steps the DAC gain toward a requested target in bounded increments with a dwell between updates.
// Latency: request strobe two cycles after a target capture when idle and enabled; one step per ack + HOLD_CYCLES.
// Backpressure: waits for the DAC updated strobe (bounded by TIMEOUT_CYCLES); no new step while dac_initdone is low.
module dac_gain_ramp_ctrl
  import dac_gain_ramp_pkg::*;
#(
  parameter int unsigned GAIN_WIDTH     = GAIN_WIDTH_DEF,
  parameter int unsigned GAIN_INIT      = GAIN_INIT_DEF,
  parameter int unsigned STEP_MAX       = STEP_MAX_DEF,
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  enable,
  input  logic                  dac_initdone,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  input  logic                  target_valid,
  input  logic                  clear_err,
  output logic [GAIN_WIDTH-1:0] dac_data_in,
  output logic                  dac_data_in_valid_stb,
  input  logic                  dac_data_in_updated_stb,
  output logic [GAIN_WIDTH-1:0] current_gain,
  output logic                  ramp_busy,
  output logic                  timeout_err
);

  // Parameter legality is enforced at elaboration.
  if (GAIN_WIDTH != 8) begin : g_bad_gain_width
    $error("dac_gain_ramp_ctrl: GAIN_WIDTH must be 8");
  end
  if (STEP_MAX < 1 || STEP_MAX > 255) begin : g_bad_step_max
    $error("dac_gain_ramp_ctrl: STEP_MAX must be in 1..255");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("dac_gain_ramp_ctrl: HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dac_gain_ramp_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  // One counter serves both the ack wait and the dwell; it counts down to zero from N-1.
  localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [GAIN_WIDTH-1:0] INIT_G    = GAIN_WIDTH'(GAIN_INIT);
  localparam logic [GAIN_WIDTH-1:0] STEP_G    = GAIN_WIDTH'(STEP_MAX);
  localparam logic [CNT_W-1:0]      TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [GAIN_WIDTH-1:0]   tgt_q, tgt_d;
  logic [GAIN_WIDTH-1:0]   next_q, next_d;
  logic [GAIN_WIDTH-1:0]   cur_q, cur_d;
  logic [GAIN_WIDTH-1:0]   dac_q, dac_d;
  logic                    stb_q, stb_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic                    step_up;
  logic [GAIN_WIDTH-1:0]   step_diff;
  logic [GAIN_WIDTH-1:0]   step_size;
  logic [GAIN_WIDTH-1:0]   step_gain;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Next gain: move toward the target by at most STEP_MAX, never past it.
  always_comb begin
    step_up   = tgt_q > cur_q;
    step_diff = step_up ? (tgt_q - cur_q) : (cur_q - tgt_q);
    step_size = (step_diff < STEP_G) ? step_diff : STEP_G;
    step_gain = step_up ? (cur_q + step_size) : (cur_q - step_size);
  end

  // FSM next-state and register updates; ack beats timeout, timeout beats clear_err.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    next_d  = next_q;
    cur_d   = cur_q;
    dac_d   = dac_q;
    stb_d   = 1'b0;
    err_d   = err_q;
    tgt_d   = target_valid ? target_gain : tgt_q;

    if (clear_err) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable && dac_initdone && (tgt_q != cur_q)) begin
          next_d  = step_gain;
          dac_d   = step_gain;
          stb_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = TO_LOAD;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (dac_data_in_updated_stb) begin
          cur_d   = next_q;
          cnt_d   = HOLD_LOAD;
          state_d = DWELL;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) || (tgt_d != cur_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= INIT_G;
      next_q  <= INIT_G;
      cur_q   <= INIT_G;
      dac_q   <= INIT_G;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      next_q  <= next_d;
      cur_q   <= cur_d;
      dac_q   <= dac_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign dac_data_in           = dac_q;
  assign dac_data_in_valid_stb = stb_q;
  assign current_gain          = cur_q;
  assign ramp_busy             = busy_q;
  assign timeout_err           = err_q;

endmodule

// File: tb/tb_dac_gain_ramp_ctrl.sv
// Purpose: directed scoreboard bench for dac_gain_ramp_ctrl (step values, timing, timeout, stray acks, reset).
// Latency: expected strobe values queued at stimulus time, popped by a monitor on each request strobe.
// Backpressure: a responder acks 3 cycles after each strobe while ack_en is set.
module tb_dac_gain_ramp_ctrl;

  localparam int HOLD    = 20;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       areset_n;
  logic       enable;
  logic       dac_initdone;
  logic [7:0] target_gain;
  logic       target_valid;
  logic       clear_err;
  logic [7:0] dac_data_in;
  logic       dac_data_in_valid_stb;
  logic       dac_data_in_updated_stb;
  logic [7:0] current_gain;
  logic       ramp_busy;
  logic       timeout_err;

  logic ack_auto;
  logic ack_man;
  logic ack_en;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  int n, n2, t, t2, t3, c, g, s;

  assign dac_data_in_updated_stb = ack_auto | ack_man;

  dac_gain_ramp_ctrl #(
    .GAIN_WIDTH    (8),
    .GAIN_INIT     (0),
    .STEP_MAX      (4),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk                    (clk),
    .areset_n               (areset_n),
    .enable                 (enable),
    .dac_initdone           (dac_initdone),
    .target_gain            (target_gain),
    .target_valid           (target_valid),
    .clear_err              (clear_err),
    .dac_data_in            (dac_data_in),
    .dac_data_in_valid_stb  (dac_data_in_valid_stb),
    .dac_data_in_updated_stb(dac_data_in_updated_stb),
    .current_gain           (current_gain),
    .ramp_busy              (ramp_busy),
    .timeout_err            (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_target(input int v, output int ncyc);
    target_gain  = 8'(v);
    target_valid = 1'b1;
    ncyc         = cyc;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic wait_stb(input int budget, output int cout);
    cout = -1;
    for (int i = 0; i < budget && cout < 0; i++) begin
      @(negedge clk);
      if (dac_data_in_valid_stb) cout = cyc;
    end
    if (cout < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_strobe: no strobe within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_busy_low(input int budget, output int cout);
    cout = -1;
    for (int i = 0; i < budget && cout < 0; i++) begin
      @(negedge clk);
      if (!ramp_busy) cout = cyc;
    end
    if (cout < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: ramp_busy still high after %0d cycles, expected low", budget);
    end
  endtask

  // Monitor: every request strobe must match the next queued expectation.
  initial begin
    int ev;
    forever begin
      @(negedge clk);
      if (dac_data_in_valid_stb) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: got strobe value %0d at cycle %0d, expected no strobe",
                   dac_data_in, cyc);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_value", int'(dac_data_in), ev);
        end
      end
    end
  end

  // Responder: ack lands in the third cycle after the strobe.
  initial begin
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_data_in_valid_stb && ack_en) begin
        repeat (3) @(negedge clk);
        ack_auto = 1'b1;
        @(negedge clk);
        ack_auto = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset_n     = 1'b0;
    enable       = 1'b0;
    dac_initdone = 1'b0;
    target_gain  = 8'd0;
    target_valid = 1'b0;
    clear_err    = 1'b0;
    ack_man      = 1'b0;
    ack_en       = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_dac_data_in", int'(dac_data_in), 0);
    chk("rst_valid_stb", int'(dac_data_in_valid_stb), 0);
    chk("rst_current_gain", int'(current_gain), 0);
    chk("rst_ramp_busy", int'(ramp_busy), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    areset_n = 1'b1;
    repeat (4) tick();
    enable       = 1'b1;
    dac_initdone = 1'b1;
    ack_en       = 1'b1;

    // Target 40 then reversed to 0 during the first ack wait: strobes 4, 0
    exp_q.push_back(4);
    exp_q.push_back(0);
    send_target(40, n);
    wait_stb(20, t);
    chk("issue_latency", t - n, 2);
    tick();
    send_target(0, n2);
    wait_stb(100, t2);
    chk("reversal_spacing", t2 - t, HOLD + 5);
    wait_busy_low(100, c);
    chk("gain_after_reversal", int'(current_gain), 0);

    // Ramp 0 -> 10: strobes 4, 8, 10 spaced HOLD+5
    exp_q.push_back(4);
    exp_q.push_back(8);
    exp_q.push_back(10);
    tick();
    send_target(10, n);
    wait_stb(20, t);
    chk("ramp_latency", t - n, 2);
    wait_stb(100, t2);
    wait_stb(100, t3);
    chk("ramp_spacing_1", t2 - t, HOLD + 5);
    chk("ramp_spacing_2", t3 - t2, HOLD + 5);
    wait_busy_low(100, c);
    chk("gain_after_ramp", int'(current_gain), 10);

    // Stray ack while idle
    tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    repeat (2) tick();
    chk("stray_idle_gain", int'(current_gain), 10);
    chk("stray_idle_busy", int'(ramp_busy), 0);

    // Stray ack during dwell must not disturb gain or dwell length
    exp_q.push_back(14);
    send_target(14, n);
    wait_stb(20, t);
    repeat (12) @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    chk("stray_dwell_gain", int'(current_gain), 14);
    wait_busy_low(100, c);
    chk("dwell_length", c - t, HOLD + 4);

    // Timeout: no ack, flag after TIMEOUT cycles, retry with same value, then clear
    ack_en = 1'b0;
    exp_q.push_back(18);
    exp_q.push_back(18);
    tick();
    send_target(18, n);
    wait_stb(20, t);
    repeat (TIMEOUT) @(negedge clk);
    chk("timeout_not_yet", int'(timeout_err), 0);
    @(negedge clk);
    chk("timeout_set", int'(timeout_err), 1);
    chk("timeout_gain_kept", int'(current_gain), 14);
    ack_en = 1'b1;
    wait_stb(20, t2);
    chk("retry_delay", t2 - t, TIMEOUT + 2);
    tick();
    chk("timeout_sticky", int'(timeout_err), 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("timeout_cleared", int'(timeout_err), 0);
    wait_busy_low(100, c);
    chk("gain_after_retry", int'(current_gain), 18);

    // Long ramp 18 -> 200, then 200 -> 197 in a single step
    g = 18;
    while (g != 200) begin
      s = (200 - g < 4) ? (200 - g) : 4;
      g = g + s;
      exp_q.push_back(g);
    end
    tick();
    send_target(200, n);
    wait_stb(20, t);
    wait_busy_low(3000, c);
    chk("gain_at_200", int'(current_gain), 200);
    exp_q.push_back(197);
    tick();
    send_target(197, n);
    wait_stb(20, t);
    wait_busy_low(100, c);
    chk("gain_at_197", int'(current_gain), 197);

    // Reset during the ack wait
    exp_q.push_back(201);
    tick();
    send_target(250, n);
    wait_stb(20, t);
    tick();
    #3;
    areset_n = 1'b0;
    #1;
    chk("midrst_dac_data_in", int'(dac_data_in), 0);
    chk("midrst_valid_stb", int'(dac_data_in_valid_stb), 0);
    chk("midrst_current_gain", int'(current_gain), 0);
    chk("midrst_ramp_busy", int'(ramp_busy), 0);
    chk("midrst_timeout_err", int'(timeout_err), 0);
    repeat (3) tick();
    areset_n = 1'b1;
    repeat (30) tick();
    chk("postrst_busy", int'(ramp_busy), 0);
    chk("postrst_gain", int'(current_gain), 0);

    // Held off while dac_initdone is low, issued once it rises
    dac_initdone = 1'b0;
    exp_q.push_back(3);
    send_target(3, n);
    repeat (10) tick();
    chk("held_pending", exp_q.size(), 1);
    chk("held_busy", int'(ramp_busy), 1);
    dac_initdone = 1'b1;
    wait_stb(20, t);
    wait_busy_low(100, c);
    chk("gain_after_release", int'(current_gain), 3);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_gain_ramp_ctrl.md
DAC_GAIN_RAMP_CTRL -- requirements
Module: dac_gain_ramp_ctrl

Interface
REQ-001 SHALL have parameter GAIN_WIDTH, default 8: gain word width; elaboration fails unless equal to 8.
REQ-002 SHALL have parameter GAIN_INIT, default 0: gain value assumed at reset.
REQ-003 SHALL have parameter STEP_MAX, default 4: maximum gain change per DAC update; elaboration fails unless in 1..255.
REQ-004 SHALL have parameter HOLD_CYCLES, default 1000: dwell time between consecutive updates; elaboration fails if less than 1.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum wait for a DAC acknowledge; elaboration fails if less than 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port areset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: permits new ramp steps.
REQ-009 SHALL have port dac_initdone, input, 1 bit: DAC controller ready; steps are issued only while it is high.
REQ-010 SHALL have port target_gain, input, GAIN_WIDTH bits: requested final gain.
REQ-011 SHALL have port target_valid, input, 1 bit: one-cycle strobe that captures target_gain.
REQ-012 SHALL have port clear_err, input, 1 bit: clears timeout_err.
REQ-013 SHALL have port dac_data_in, output, GAIN_WIDTH bits: next gain sent to the downstream DAC controller.
REQ-014 SHALL have port dac_data_in_valid_stb, output, 1 bit: one-cycle request strobe.
REQ-015 SHALL have port dac_data_in_updated_stb, input, 1 bit: DAC controller SPI-complete strobe.
REQ-016 SHALL have port current_gain, output, GAIN_WIDTH bits: last acknowledged gain.
REQ-017 SHALL have port ramp_busy, output, 1 bit: high when state is not IDLE or target differs from current_gain.
REQ-018 SHALL have port timeout_err, output, 1 bit: sticky acknowledge-timeout flag.

Function
REQ-019 SHALL register target_gain into target_reg on any cycle target_valid is high, in every state; the latest capture wins.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK and DWELL.
REQ-021 SHALL, in IDLE when enable, dac_initdone and target_reg != current_gain, load next_gain = current_gain ± min(STEP_MAX, |target_reg − current_gain|) and enter ISSUE.
- Arithmetic is unsigned and never overshoots or wraps.
REQ-022 SHALL, in ISSUE, assert dac_data_in_valid_stb for exactly one cycle with dac_data_in = next_gain, then enter WAIT_ACK with the shared counter loaded.
REQ-023 SHALL hold dac_data_in stable from ISSUE until WAIT_ACK exits.
REQ-024 SHALL, in WAIT_ACK on dac_data_in_updated_stb, set current_gain to next_gain and enter DWELL.
REQ-025 SHALL, in WAIT_ACK after TIMEOUT_CYCLES cycles without acknowledge, set timeout_err, leave current_gain unchanged and return to IDLE; the step then retries.
REQ-026 SHALL remain in DWELL exactly HOLD_CYCLES cycles, then enter IDLE.
REQ-027 SHALL ignore dac_data_in_updated_stb outside WAIT_ACK; such strobes come from MMI or reset-default writes.
REQ-028 SHALL, on deassertion of enable during WAIT_ACK or DWELL, complete that phase and then stay in IDLE.
REQ-029 SHALL give priority to the acknowledge over the timeout when both occur in the same cycle.
REQ-030 SHALL clear timeout_err on clear_err unless a timeout occurs in the same cycle, in which case set wins.
REQ-031 SHALL, for target_valid sampled in cycle N while in IDLE with all conditions true, assert dac_data_in_valid_stb in cycle N+2.
REQ-032 SHALL drive all outputs from registers.

Reset
REQ-033 SHALL, while areset_n is low and asynchronously, set:
- state to IDLE;
- current_gain, target_reg, next_gain and dac_data_in to GAIN_INIT;
- dac_data_in_valid_stb, timeout_err and the counter to 0.
REQ-034 SHALL release reset synchronously to clk.
REQ-035 SHALL, when reset asserts mid-ramp, abandon the outstanding step; current_gain reflects GAIN_INIT, not the DAC contents.

Structure
REQ-036 SHALL place the state_t enum and default parameter constants in shared package dac_gain_ramp_pkg.
REQ-037 SHALL use one down-counter, sized for the larger of HOLD_CYCLES and TIMEOUT_CYCLES, shared between WAIT_ACK and DWELL; no sub-module is warranted.

Verification
REQ-038 SHALL cover: GAIN_INIT=0, STEP_MAX=4, target 10, ack 3 cycles after each strobe -> strobes carry 4, 8, 10 in that order, strobes spaced HOLD_CYCLES+5 cycles apart, current_gain ends at 10.
REQ-039 SHALL cover: from 200, target 197 -> a single strobe with value 197, no undershoot.
REQ-040 SHALL cover: TIMEOUT_CYCLES=16, no ack -> timeout_err set 16 cycles after entering WAIT_ACK, current_gain unchanged, retry strobe has the same value; clear_err then drops the flag.
REQ-041 SHALL cover: a stray updated_stb in IDLE and in DWELL -> no change in current_gain or state.
REQ-042 SHALL cover: target changed from 40 to 0 during WAIT_ACK of step 4 -> after the ack, the next strobe carries 0 (from 4, STEP_MAX=4).
REQ-043 SHALL cover: areset_n pulsed low during WAIT_ACK -> all outputs take reset values immediately, and no strobe occurs until a valid target is presented with dac_initdone high.
